// File: rtl/keyled_cpu_jtag_ocimem_ctrl.sv
// keyled CPU debug-RAM access controller: turns JTAG ocimem strobes into
// single-word reads/writes on the on-chip debug RAM.
module keyled_cpu_jtag_ocimem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [31:0]       ram_readdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [31:0]       mon_d_q, mon_d_d;
    logic              err_q, err_d;

    logic              any_strobe;
    logic              multi_strobe;
    logic              err_set;
    logic              err_clr;
    logic [ADDR_W-1:0] mon_a_inc;
    logic              unused_jdo;

    assign unused_jdo = ^jdo;

    assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a
                      | take_action_ocimem_b;

    assign multi_strobe = (take_action_ocimem_b & take_action_ocimem_a)
                        | (take_action_ocimem_b & take_no_action_ocimem_a)
                        | (take_action_ocimem_a & take_no_action_ocimem_a);

    // wraps modulo 2^ADDR_W by construction
    assign mon_a_inc = mon_a_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        mon_a_d = mon_a_q;
        mon_d_d = mon_d_q;
        err_set = 1'b0;
        err_clr = 1'b0;
        ram_re  = 1'b0;
        ram_we  = 1'b0;

        unique case (state_q)
            IDLE: begin
                err_set = multi_strobe;
                if (take_action_ocimem_b) begin
                    mon_d_d = jdo[34:3];
                    state_d = WR;
                end else if (take_action_ocimem_a) begin
                    mon_a_d = jdo[ADDR_W+1:2];
                    err_clr = jdo[18];
                    if (jdo[17]) begin
                        state_d = RD_REQ;
                    end
                end else if (take_no_action_ocimem_a) begin
                    mon_a_d = mon_a_inc;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                err_set = any_strobe;
                ram_re  = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                err_set = any_strobe;
                mon_d_d = ram_readdata;
                state_d = IDLE;
            end
            WR: begin
                err_set = any_strobe;
                ram_we  = 1'b1;
                mon_a_d = mon_a_inc;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // a set in the same cycle as a clear must win
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mon_a_q <= '0;
            mon_d_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mon_a_q <= mon_a_d;
            mon_d_q <= mon_d_d;
            err_q   <= err_d;
        end
    end

    assign ram_addr      = mon_a_q;
    assign ram_wdata     = mon_d_q;
    assign MonDReg       = mon_d_q;
    assign monitor_ready = (state_q == IDLE);
    assign monitor_error = err_q;

endmodule
